// File: rtl/vec_store_sequencer.sv
// Vector store sequencer: captures one vector plus a base address and writes it
// to the data memory one element per accepted cycle at consecutive addresses.
// Holds busy (pipeline stall) for the whole sequence and pulses done at the end.
module vec_store_sequencer #(
  parameter int unsigned ELEMENTS = 16,
  parameter int unsigned ELEM_W   = 16,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [ELEMENTS*ELEM_W-1:0]   vec_data_i,
  input  logic                         mem_ready_i,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [ELEM_W-1:0]            mem_wdata_o,
  output logic                         mem_we_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned IdxW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                       state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [ADDR_W-1:0]            base_q, base_d;
  logic [ELEMENTS*ELEM_W-1:0]   vec_q, vec_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [ELEM_W-1:0]            wdata_q, wdata_d;
  logic                         we_q, busy_q, done_q;
  logic                         last_idx;

  assign last_idx = (idx_q == IdxW'(ELEMENTS - 1));

  // Next-state: capture on start in idle, advance index on each accepted write.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_addr_i;
          vec_d   = vec_data_i;
          idx_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (mem_ready_i) begin
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory-side values for the next cycle; address wraps naturally in ADDR_W bits.
  always_comb begin
    addr_d  = base_d + ADDR_W'(idx_d);
    wdata_d = vec_d[idx_d*ELEM_W +: ELEM_W];
  end

  // State and registered outputs; synchronous reset abandons any sequence in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      base_q  <= '0;
      vec_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      vec_q   <= vec_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= (state_d == StWrite);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
